// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - MEM/WB boundary and register-file write port bundle
interface writeback_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     link_pc;
  logic [DATA_W-1:0]     imm_data;
  logic [1:0]            wb_sel;
  logic [1:0]            ld_size;
  logic                  ld_unsigned;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] dest_in;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  wb_valid;
  logic                  align_err;
  logic [CNT_W-1:0]      retire_cnt;

  modport master (
    output in_valid, stall, flush, alu_result, mem_rdata, link_pc, imm_data,
           wb_sel, ld_size, ld_unsigned, reg_write, dest_in,
    input  rf_we, rf_waddr, rf_wdata, wb_valid, align_err, retire_cnt
  );

  modport slave (
    input  in_valid, stall, flush, alu_result, mem_rdata, link_pc, imm_data,
           wb_sel, ld_size, ld_unsigned, reg_write, dest_in,
    output rf_we, rf_waddr, rf_wdata, wb_valid, align_err, retire_cnt
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, load alignment/extension, register-file write port
module writeback_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                  valid_q, valid_d;
  logic                  held_q, held_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [DATA_W-1:0]     link_q, link_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [1:0]            wb_sel_q, wb_sel_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [OFF_W-1:0]      off;
  logic [OFF_W-1:0]      align_mask;
  logic [1:0]            eff_size;
  logic [DATA_W-1:0]     shifted;
  logic [DATA_W-1:0]     low_mask;
  logic                  sign_bit;
  logic [DATA_W-1:0]     load_val;
  logic                  misaligned;
  logic                  rf_we;

  // Load lane extraction and extension from the registered fields only.
  always_comb begin
    off      = alu_q[OFF_W-1:0];
    eff_size = (DATA_W == 32 && ld_size_q == 2'b11) ? 2'b10 : ld_size_q;
    shifted  = rdata_q >> {off, 3'b000};
    case (eff_size)
      2'b00: begin
        low_mask   = DATA_W'(8'hFF);
        sign_bit   = shifted[7];
        align_mask = '0;
      end
      2'b01: begin
        low_mask   = DATA_W'(16'hFFFF);
        sign_bit   = shifted[15];
        align_mask = OFF_W'(3'd1);
      end
      2'b10: begin
        low_mask   = DATA_W'(32'hFFFF_FFFF);
        sign_bit   = shifted[31];
        align_mask = OFF_W'(3'd3);
      end
      default: begin
        low_mask   = '1;
        sign_bit   = shifted[DATA_W-1];
        align_mask = OFF_W'(3'd7);
      end
    endcase
    load_val   = (shifted & low_mask) | ((!ld_uns_q && sign_bit) ? ~low_mask : '0);
    misaligned = (wb_sel_q == 2'b01) && ((off & align_mask) != '0);
    // held_q marks the repeat cycles of a stalled instruction: its write already happened.
    rf_we      = valid_q && reg_write_q && (dest_q != '0) && !misaligned && !held_q;
  end

  always_comb begin
    valid_d     = valid_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    link_d      = link_q;
    imm_d       = imm_q;
    wb_sel_d    = wb_sel_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    reg_write_d = reg_write_q;
    dest_d      = dest_q;
    held_d      = bus.stall;
    if (!bus.stall) begin
      valid_d     = bus.in_valid;
      alu_d       = bus.alu_result;
      rdata_d     = bus.mem_rdata;
      link_d      = bus.link_pc;
      imm_d       = bus.imm_data;
      wb_sel_d    = bus.wb_sel;
      ld_size_d   = bus.ld_size;
      ld_uns_d    = bus.ld_unsigned;
      reg_write_d = bus.reg_write;
      dest_d      = bus.dest_in;
    end
    if (bus.flush) begin
      valid_d = 1'b0;
    end
    // rf_we is already one cycle per instruction, so every asserted cycle is one retirement.
    cnt_d = cnt_q + CNT_W'(rf_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      alu_q       <= '0;
      rdata_q     <= '0;
      link_q      <= '0;
      imm_q       <= '0;
      wb_sel_q    <= '0;
      ld_size_q   <= '0;
      ld_uns_q    <= 1'b0;
      reg_write_q <= 1'b0;
      dest_q      <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      held_q      <= held_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      link_q      <= link_d;
      imm_q       <= imm_d;
      wb_sel_q    <= wb_sel_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      reg_write_q <= reg_write_d;
      dest_q      <= dest_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    case (wb_sel_q)
      2'b00:   bus.rf_wdata = alu_q;
      2'b01:   bus.rf_wdata = load_val;
      2'b10:   bus.rf_wdata = link_q;
      default: bus.rf_wdata = imm_q;
    endcase
  end

  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = dest_q;
  assign bus.wb_valid   = valid_q;
  assign bus.align_err  = valid_q && misaligned && !held_q;
  assign bus.retire_cnt = cnt_q;
endmodule
